// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program-counter / instruction-fetch sequencer for the CPU front end.
//
// Generates the instruction-ROM fetch address. Supports:
//   - NUM_EXC exception vectors
//   - a return-address stack, so exception handlers can nest
//   - a sticky halt state
//   - absolute or PC-relative branches
//
// Ports:
//   CLK        rising-edge clock
//   Init       asynchronous active-high reset
//   Branch     take a branch this cycle
//   Target     branch-target field from the instruction
//   Stall      hazard hold: PC and stack keep their values
//   done       program finished; enter the sticky halt state
//   exp_error  exception cause: 0 = none, 1..NUM_EXC = vector, larger = bad code
//   ExcRet     return from the current exception handler
//   PC         current fetch address
//   halted     high while in the halt state
//   exc_depth  return-stack occupancy
//   rs_ovf     sticky: a push was attempted while the stack was full
//   rs_unf     sticky: ExcRet was seen while the stack was empty
//   bad_exc    one-cycle pulse after an out-of-range exception code
module fetch_pc_unit #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned TGT_W      = 3,
  parameter int unsigned TGT_SHIFT  = 5,
  parameter int unsigned BR_MODE    = 0,
  parameter int unsigned NUM_EXC    = 2,
  parameter int unsigned EXC_W      = 2,
  parameter int unsigned EXC_BASE   = 256,
  parameter int unsigned EXC_STRIDE = 32,
  parameter int unsigned RS_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          Init,
  input  logic                          Branch,
  input  logic [TGT_W-1:0]              Target,
  input  logic                          Stall,
  input  logic                          done,
  input  logic [EXC_W-1:0]              exp_error,
  input  logic                          ExcRet,
  output logic [PC_W-1:0]               PC,
  output logic                          halted,
  output logic [$clog2(RS_DEPTH):0]     exc_depth,
  output logic                          rs_ovf,
  output logic                          rs_unf,
  output logic                          bad_exc
);

  localparam int unsigned SpW = $clog2(RS_DEPTH);

  typedef enum logic {StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [SpW:0]    depth_q, depth_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            bad_q, bad_d;

  // Stack contents need no reset: exc_depth alone decides which entries are live.
  logic [PC_W-1:0] stack_q [RS_DEPTH];
  logic            push;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_vec;
  logic [PC_W-1:0] br_tgt;
  logic [SpW-1:0]  top_idx;
  logic [SpW-1:0]  push_idx;
  logic            exc_valid;
  logic            exc_bad;
  logic            stack_full;

  assign pc_inc     = pc_q + PC_W'(1);
  // Vector math is done directly at PC_W width, which truncates it modulo 2^PC_W.
  assign pc_vec     = PC_W'(EXC_BASE) + PC_W'(32'(exp_error) - 32'd1) * PC_W'(EXC_STRIDE);
  assign exc_valid  = (exp_error != '0) && (32'(exp_error) <= NUM_EXC);
  assign exc_bad    = 32'(exp_error) > NUM_EXC;
  assign stack_full = depth_q == (SpW+1)'(RS_DEPTH);
  assign top_idx    = SpW'(depth_q - (SpW+1)'(1));
  assign push_idx   = SpW'(depth_q);

  // Absolute mode zero-extends and scales the target; relative mode sign-extends it.
  always_comb begin
    br_tgt = '0;
    if (BR_MODE == 0) begin
      br_tgt = PC_W'(Target) << TGT_SHIFT;
    end else begin
      br_tgt = pc_q + {{(PC_W-TGT_W){Target[TGT_W-1]}}, Target};
    end
  end

  // Next-state logic. Only the highest-priority event acts; the rest are dropped.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    bad_d   = 1'b0;
    push    = 1'b0;
    if (state_q == StRun) begin
      if (done) begin
        state_d = StHalt;
      end else if (Stall) begin
        // Hold everything; the hazard unit re-presents any dropped request.
      end else if (exc_valid) begin
        pc_d = pc_vec;
        if (stack_full) begin
          ovf_d = 1'b1;
        end else begin
          push    = 1'b1;
          depth_d = depth_q + (SpW+1)'(1);
        end
      end else if (exc_bad) begin
        bad_d = 1'b1;
      end else if (ExcRet) begin
        if (depth_q != '0) begin
          pc_d    = stack_q[top_idx];
          depth_d = depth_q - (SpW+1)'(1);
        end else begin
          unf_d = 1'b1;
          pc_d  = pc_inc;
        end
      end else if (Branch) begin
        pc_d = br_tgt;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      state_q <= StRun;
      pc_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      bad_q   <= bad_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign PC        = pc_q;
  assign halted    = state_q == StHalt;
  assign exc_depth = depth_q;
  assign rs_ovf    = ovf_q;
  assign rs_unf    = unf_q;
  assign bad_exc   = bad_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: one absolute-branch and one relative-branch instance share inputs.
module tb_fetch_pc_unit;

  localparam int M = 1024;

  logic       CLK = 1'b0;
  logic       Init = 1'b0, Branch = 1'b0, Stall = 1'b0, done = 1'b0, ExcRet = 1'b0;
  logic [2:0] Target = '0;
  logic [1:0] exp_error = '0;

  logic [9:0] pc0, pc1;
  logic       halt0, halt1, ovf0, ovf1, unf0, unf1, bad0, bad1;
  logic [2:0] dep0, dep1;

  int vectors = 0;
  int errors  = 0;

  // Reference model state, index 0 = absolute, 1 = relative
  int m_pc [2];
  bit m_halt [2], m_ovf [2], m_unf [2], m_bad [2];
  int q0 [$];
  int q1 [$];

  always #5 CLK = ~CLK;

  fetch_pc_unit #(.BR_MODE(0)) u_abs (
    .CLK(CLK), .Init(Init), .Branch(Branch), .Target(Target), .Stall(Stall), .done(done),
    .exp_error(exp_error), .ExcRet(ExcRet), .PC(pc0), .halted(halt0), .exc_depth(dep0),
    .rs_ovf(ovf0), .rs_unf(unf0), .bad_exc(bad0)
  );

  fetch_pc_unit #(.BR_MODE(1)) u_rel (
    .CLK(CLK), .Init(Init), .Branch(Branch), .Target(Target), .Stall(Stall), .done(done),
    .exp_error(exp_error), .ExcRet(ExcRet), .PC(pc1), .halted(halt1), .exc_depth(dep1),
    .rs_ovf(ovf1), .rs_unf(unf1), .bad_exc(bad1)
  );

  function automatic logic [16:0] got(int i);
    if (i == 0) return {pc0, halt0, dep0, ovf0, unf0, bad0};
    return {pc1, halt1, dep1, ovf1, unf1, bad1};
  endfunction

  function automatic logic [16:0] want(int i);
    int d;
    d = (i == 0) ? q0.size() : q1.size();
    return {10'(m_pc[i]), m_halt[i], 3'(d), m_ovf[i], m_unf[i], m_bad[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 0; m_halt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_bad[i] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int pc;
      int d;
      int e;
      int t;
      pc = m_pc[i];
      d  = (i == 0) ? q0.size() : q1.size();
      e  = int'(exp_error);
      t  = int'(Target);
      m_bad[i] = 0;
      if (m_halt[i]) begin
      end else if (done) begin
        m_halt[i] = 1;
      end else if (Stall) begin
      end else if (e >= 1 && e <= 2) begin
        m_pc[i] = (256 + (e - 1) * 32) % M;
        if (d < 4) begin
          if (i == 0) q0.push_back((pc + 1) % M); else q1.push_back((pc + 1) % M);
        end else begin
          m_ovf[i] = 1;
        end
      end else if (e > 2) begin
        m_bad[i] = 1;
      end else if (ExcRet) begin
        if (d > 0) m_pc[i] = (i == 0) ? q0.pop_back() : q1.pop_back();
        else begin
          m_unf[i] = 1;
          m_pc[i]  = (pc + 1) % M;
        end
      end else if (Branch) begin
        if (i == 0) m_pc[i] = (t * 32) % M;
        else begin
          if (t >= 4) t = t - 8;
          m_pc[i] = ((pc + t) % M + M) % M;
        end
      end else begin
        m_pc[i] = (pc + 1) % M;
      end
    end
  endtask

  task automatic clear_inputs();
    Branch = 0; Stall = 0; done = 0; ExcRet = 0; exp_error = 0; Target = 0;
  endtask

  // Advance one clock; sampling happens 1 time unit after the edge.
  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(int n);
    clear_inputs();
    repeat (n) cycle();
  endtask

  task automatic do_init();
    Init = 1;
    #2;
    Init = 0;
    model_reset();
  endtask

  task automatic test_reset();
    clear_inputs();
    do_init();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (got(i) !== 17'd0) begin
        errors++;
        $display("FAIL reset inst%0d: got %h want 0", i, got(i));
      end
    end
    for (int k = 1; k <= 5; k++) begin
      cycle();
      vectors++;
      if (pc0 !== 10'(k) || pc1 !== 10'(k) || halt0 !== 1'b0) begin
        errors++;
        $display("FAIL idle_count step %0d: got pc %0d/%0d halted %b want %0d/%0d halted 0",
                 k, pc0, pc1, halt0, k, k);
      end
    end
  endtask

  task automatic test_branch();
    idle(0);
    Target = 3'd3; Branch = 1;
    cycle();
    clear_inputs();
    vectors++;
    if (pc0 !== 10'd96 || pc1 !== 10'd8) begin
      errors++;
      $display("FAIL branch_fwd: got %0d/%0d want 96/8", pc0, pc1);
    end
    do_init();
    idle(10);
    Target = 3'b110; Branch = 1;
    cycle();
    clear_inputs();
    vectors++;
    if (pc0 !== 10'd192 || pc1 !== 10'd8) begin
      errors++;
      $display("FAIL branch_back: got %0d/%0d want 192/8", pc0, pc1);
    end
  endtask

  task automatic test_exception();
    do_init();
    idle(20);
    exp_error = 2'd1;
    cycle();
    clear_inputs();
    vectors++;
    if (pc0 !== 10'd256 || dep0 !== 3'd1 || pc1 !== 10'd256 || dep1 !== 3'd1) begin
      errors++;
      $display("FAIL exc_enter: got pc %0d depth %0d want 256 depth 1", pc0, dep0);
    end
    idle(3);
    vectors++;
    if (pc0 !== 10'd259) begin
      errors++;
      $display("FAIL exc_handler: got %0d want 259", pc0);
    end
    ExcRet = 1;
    cycle();
    clear_inputs();
    vectors++;
    if (pc0 !== 10'd21 || dep0 !== 3'd0 || pc1 !== 10'd21 || dep1 !== 3'd0) begin
      errors++;
      $display("FAIL exc_return: got pc %0d depth %0d want 21 depth 0", pc0, dep0);
    end
  endtask

  task automatic test_nested();
    do_init();
    idle(20);
    exp_error = 2'd1;
    cycle();
    exp_error = 2'd2;
    cycle();
    clear_inputs();
    vectors++;
    if (pc0 !== 10'd288 || dep0 !== 3'd2) begin
      errors++;
      $display("FAIL nest_enter: got pc %0d depth %0d want 288 depth 2", pc0, dep0);
    end
    ExcRet = 1;
    cycle();
    vectors++;
    if (pc0 !== 10'd257 || dep0 !== 3'd1) begin
      errors++;
      $display("FAIL nest_ret1: got pc %0d depth %0d want 257 depth 1", pc0, dep0);
    end
    cycle();
    clear_inputs();
    vectors++;
    if (pc0 !== 10'd21 || dep0 !== 3'd0) begin
      errors++;
      $display("FAIL nest_ret2: got pc %0d depth %0d want 21 depth 0", pc0, dep0);
    end
    do_init();
    idle(2);
    for (int k = 0; k < 5; k++) begin
      exp_error = 2'((k % 2) + 1);
      cycle();
      if (k == 3) begin
        vectors++;
        if (ovf0 !== 1'b0 || dep0 !== 3'd4) begin
          errors++;
          $display("FAIL ovf_early: got ovf %b depth %0d want 0 depth 4", ovf0, dep0);
        end
      end
    end
    clear_inputs();
    vectors++;
    if (ovf0 !== 1'b1 || dep0 !== 3'd4 || pc0 !== 10'd256 || ovf1 !== 1'b1) begin
      errors++;
      $display("FAIL ovf: got ovf %b depth %0d pc %0d want 1 4 256", ovf0, dep0, pc0);
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (got(i) !== want(i)) begin
        errors++;
        $display("FAIL ovf_model inst%0d: got %h want %h", i, got(i), want(i));
      end
    end
  endtask

  task automatic test_conflicts();
    do_init();
    idle(3);
    Stall = 1; exp_error = 2'd1; Branch = 1; Target = 3'd5;
    cycle();
    clear_inputs();
    vectors++;
    if (pc0 !== 10'd3 || pc1 !== 10'd3 || dep0 !== 3'd0) begin
      errors++;
      $display("FAIL stall_wins: got pc %0d/%0d depth %0d want 3/3 depth 0", pc0, pc1, dep0);
    end
    exp_error = 2'd3; Branch = 1;
    cycle();
    clear_inputs();
    vectors++;
    if (pc0 !== 10'd3 || bad0 !== 1'b1 || dep0 !== 3'd0) begin
      errors++;
      $display("FAIL bad_exc: got pc %0d bad %b want 3 bad 1", pc0, bad0);
    end
    cycle();
    vectors++;
    if (pc0 !== 10'd4 || bad0 !== 1'b0) begin
      errors++;
      $display("FAIL bad_exc_pulse: got pc %0d bad %b want 4 bad 0", pc0, bad0);
    end
    ExcRet = 1;
    cycle();
    clear_inputs();
    vectors++;
    if (pc0 !== 10'd5 || unf0 !== 1'b1 || unf1 !== 1'b1) begin
      errors++;
      $display("FAIL underflow: got pc %0d unf %b want 5 unf 1", pc0, unf0);
    end
    cycle();
    vectors++;
    if (pc0 !== 10'd6 || unf0 !== 1'b1) begin
      errors++;
      $display("FAIL unf_sticky: got pc %0d unf %b want 6 unf 1", pc0, unf0);
    end
  endtask

  task automatic test_halt();
    do_init();
    idle(7);
    done = 1;
    cycle();
    clear_inputs();
    vectors++;
    if (pc0 !== 10'd7 || halt0 !== 1'b1 || halt1 !== 1'b1) begin
      errors++;
      $display("FAIL halt_enter: got pc %0d halted %b want 7 halted 1", pc0, halt0);
    end
    Branch = 1; exp_error = 2'd1; ExcRet = 1; Target = 3'd2;
    repeat (3) cycle();
    clear_inputs();
    vectors++;
    if (pc0 !== 10'd7 || pc1 !== 10'd7 || dep0 !== 3'd0 || halt0 !== 1'b1) begin
      errors++;
      $display("FAIL halt_frozen: got pc %0d/%0d depth %0d want 7/7 depth 0", pc0, pc1, dep0);
    end
    // Asynchronous reset lands between edges.
    Init = 1;
    #2;
    vectors++;
    if (pc0 !== 10'd0 || halt0 !== 1'b0 || pc1 !== 10'd0) begin
      errors++;
      $display("FAIL async_init: got pc %0d halted %b want 0 halted 0", pc0, halt0);
    end
    Init = 0;
    model_reset();
    idle(2);
    exp_error = 2'd2;
    cycle();
    clear_inputs();
    Init = 1;
    #2;
    vectors++;
    if (dep0 !== 3'd0 || pc0 !== 10'd0) begin
      errors++;
      $display("FAIL init_mid_handler: got depth %0d pc %0d want 0 0", dep0, pc0);
    end
    Init = 0;
    model_reset();
  endtask

  task automatic test_wrap();
    do_init();
    Branch = 1; Target = 3'd7;
    cycle();
    Branch = 0;
    vectors++;
    if (pc0 !== 10'd224 || pc1 !== 10'd1023) begin
      errors++;
      $display("FAIL rel_wrap_back: got %0d/%0d want 224/1023", pc0, pc1);
    end
    cycle();
    vectors++;
    if (pc1 !== 10'd0) begin
      errors++;
      $display("FAIL inc_wrap_rel: got %0d want 0", pc1);
    end
    Branch = 1; Target = 3'd7;
    cycle();
    Target = 3'd3;
    cycle();
    clear_inputs();
    vectors++;
    if (pc1 !== 10'd2 || pc0 !== 10'd96) begin
      errors++;
      $display("FAIL rel_wrap_fwd: got %0d/%0d want 96/2", pc0, pc1);
    end
    do_init();
    Branch = 1; Target = 3'd7;
    cycle();
    idle(799);
    vectors++;
    if (pc0 !== 10'd1023) begin
      errors++;
      $display("FAIL reach_top: got %0d want 1023", pc0);
    end
    cycle();
    vectors++;
    if (pc0 !== 10'd0) begin
      errors++;
      $display("FAIL inc_wrap: got %0d want 0", pc0);
    end
  endtask

  task automatic test_random();
    do_init();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) < 2) begin
        do_init();
      end else begin
        Stall     = $urandom_range(99) < 15;
        Branch    = $urandom_range(99) < 25;
        ExcRet    = $urandom_range(99) < 20;
        done      = $urandom_range(99) < 1;
        exp_error = ($urandom_range(99) < 25) ? 2'($urandom_range(3)) : 2'd0;
        Target    = 3'($urandom);
        cycle();
      end
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got(i) !== want(i)) begin
          errors++;
          $display("FAIL random step %0d inst%0d: got %h want %h", n, i, got(i), want(i));
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_branch();
    test_exception();
    test_nested();
    test_conflicts();
    test_halt();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
